// File: rtl/channel_accum_binarize.sv
// channel_accum_binarize: accumulates CHANNEL_CNT partial-sum beats per neuron,
// then emits a saturated frame sum and a binarized activation (sum >= threshold).
//
// Ports:
//   i_clk        rising-edge clock
//   i_rst        asynchronous active-high reset
//   i_flush      synchronous frame abort; clears the partial frame, blocks input
//   i_in_valid   upstream beat valid
//   o_in_ready   beat accepted this cycle when high together with i_in_valid
//   i_in_data    OUTPUT_DIM signed BIT_CNT-wide partial sums
//   i_threshold  OUTPUT_DIM signed ACC_W-wide thresholds, sampled on the last beat
//   o_out_valid  result register holds an undelivered frame
//   i_out_ready  downstream accepts the result
//   o_out_sum    OUTPUT_DIM saturated BIT_CNT-wide frame sums
//   o_out_bin    OUTPUT_DIM activation bits
module channel_accum_binarize #(
    parameter  int OUTPUT_DIM  = 4,
    parameter  int BIT_CNT     = 8,
    parameter  int CHANNEL_CNT = 4,
    localparam int ACC_W       = BIT_CNT + $clog2(CHANNEL_CNT),
    localparam int CNT_W       = $clog2(CHANNEL_CNT)
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic                               i_flush,
    input  logic                               i_in_valid,
    output logic                               o_in_ready,
    input  logic [OUTPUT_DIM-1:0][BIT_CNT-1:0] i_in_data,
    input  logic [OUTPUT_DIM-1:0][ACC_W-1:0]   i_threshold,
    output logic                               o_out_valid,
    input  logic                               i_out_ready,
    output logic [OUTPUT_DIM-1:0][BIT_CNT-1:0] o_out_sum,
    output logic [OUTPUT_DIM-1:0]              o_out_bin
);

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (BIT_CNT - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    logic [CNT_W-1:0]                 r_cnt;
    logic [OUTPUT_DIM-1:0][ACC_W-1:0] r_acc;
    logic                             r_out_valid;
    logic [OUTPUT_DIM-1:0][BIT_CNT-1:0] r_out_sum;
    logic [OUTPUT_DIM-1:0]            r_out_bin;

    logic                               w_first;
    logic                               w_last;
    logic                               w_accept;
    logic [OUTPUT_DIM-1:0][ACC_W-1:0]   w_ext;
    logic [OUTPUT_DIM-1:0][ACC_W-1:0]   w_total;
    logic [OUTPUT_DIM-1:0][BIT_CNT-1:0] w_sat;
    logic [OUTPUT_DIM-1:0]              w_bin;

    assign w_first  = r_cnt == '0;
    assign w_last   = r_cnt == CNT_W'(CHANNEL_CNT - 1);
    // Only the closing beat of a frame needs the result register free.
    assign o_in_ready = !i_flush && !(w_last && r_out_valid && !i_out_ready);
    assign w_accept   = i_in_valid && o_in_ready;

    assign o_out_valid = r_out_valid;
    assign o_out_sum   = r_out_sum;
    assign o_out_bin   = r_out_bin;

    // ACC_W is sized so the full frame total never overflows; clamping
    // happens only when narrowing to the BIT_CNT-wide output.
    always_comb begin
        w_ext   = '0;
        w_total = '0;
        w_sat   = '0;
        w_bin   = '0;
        for (int i = 0; i < OUTPUT_DIM; i++) begin
            w_ext[i]   = {{(ACC_W - BIT_CNT){i_in_data[i][BIT_CNT-1]}}, i_in_data[i]};
            w_total[i] = r_acc[i] + w_ext[i];
            w_sat[i]   = $signed(w_total[i]) > SAT_MAX ? BIT_CNT'(SAT_MAX) :
                         $signed(w_total[i]) < SAT_MIN ? BIT_CNT'(SAT_MIN) :
                         w_total[i][BIT_CNT-1:0];
            w_bin[i]   = $signed(w_total[i]) >= $signed(i_threshold[i]);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt       <= '0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_bin   <= '0;
        end else begin
            if (i_flush) begin
                r_cnt <= '0;
                r_acc <= '0;
            end else if (w_accept) begin
                r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
                // First beat loads so no stale frame leaks in; last beat goes
                // straight to the output and leaves the accumulator alone.
                for (int i = 0; i < OUTPUT_DIM; i++)
                    if (w_first)
                        r_acc[i] <= w_ext[i];
                    else if (!w_last)
                        r_acc[i] <= w_total[i];
            end
            if (w_accept && w_last) begin
                r_out_valid <= 1'b1;
                r_out_sum   <= w_sat;
                r_out_bin   <= w_bin;
            end else if (r_out_valid && i_out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_channel_accum_binarize.sv
// tb_channel_accum_binarize: scoreboard bench for channel_accum_binarize.
module tb_channel_accum_binarize;

    localparam int OD = 4;
    localparam int BC = 8;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic rst, flush, in_valid, in_ready, out_ready, out_valid;
    logic [OD-1:0][BC-1:0] in_data, out_sum;
    logic [OD-1:0][AW-1:0] thr;
    logic [OD-1:0]         out_bin;

    typedef struct packed {
        logic [OD-1:0][BC-1:0] s;
        logic [OD-1:0]         b;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    channel_accum_binarize dut (
        .i_clk(clk), .i_rst(rst), .i_flush(flush),
        .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data),
        .i_threshold(thr),
        .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_out_sum(out_sum), .o_out_bin(out_bin)
    );

    always #5 clk = ~clk;

    function automatic logic [OD-1:0][BC-1:0] v(input int a, input int b, input int c, input int d);
        return {BC'(d), BC'(c), BC'(b), BC'(a)};
    endfunction

    function automatic logic [OD-1:0][AW-1:0] tv(input int a, input int b, input int c, input int d);
        return {AW'(d), AW'(c), AW'(b), AW'(a)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_output: got sum %h bin %b with no frame expected", out_sum, out_bin);
                end else begin
                    exp_t e = q.pop_front();
                    check("out_sum", 64'(out_sum), 64'(e.s));
                    check("out_bin", 64'(out_bin), 64'(e.b));
                end
            end
        end
    endtask

    task automatic beat(input logic [OD-1:0][BC-1:0] d);
        bit ok = 0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL beat_timeout: in_ready 0 expected 1 within 50 cycles");
        end
    endtask

    task automatic frame(input logic [OD-1:0][BC-1:0] d0, input logic [OD-1:0][BC-1:0] d1,
                         input logic [OD-1:0][BC-1:0] d2, input logic [OD-1:0][BC-1:0] d3,
                         input logic [OD-1:0][BC-1:0] es, input logic [OD-1:0] eb, input bit push);
        if (push) q.push_back('{s: es, b: eb});
        beat(d0);
        beat(d1);
        beat(d2);
        beat(d3);
        check("latency_valid", 64'(out_valid), 64'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() != 0; i++) @(posedge clk);
        #1;
        check("drain_queue_empty", 64'(q.size()), 64'd0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; thr = '0; out_ready = 1'b1;
        fork monitor(); join_none
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_sum", 64'(out_sum), 64'd0);
        check("rst_out_bin", 64'(out_bin), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic, saturation both ways, threshold equality; frames back-to-back.
        thr = '0;
        frame(v(10, -3, 100, -100), v(20, -3, 100, -100), v(-5, -3, 0, -100), v(7, -3, 0, 0),
              v(32, -12, 127, -128), 4'b0101, 1);
        thr = tv(0, 500, 0, 0);
        frame(v(0, 127, 0, 0), v(0, 127, 0, 0), v(0, 127, 0, 0), v(0, 127, 0, 0),
              v(0, 127, 0, 0), 4'b1111, 1);
        thr = tv(0, 509, 0, 0);
        frame(v(0, 127, 0, 0), v(0, 127, 0, 0), v(0, 127, 0, 0), v(0, 127, 0, 0),
              v(0, 127, 0, 0), 4'b1101, 1);
        thr = tv(-512, -511, -512, -511);
        frame(v(-128, -128, -128, -128), v(-128, -128, -128, -128),
              v(-128, -128, -128, -128), v(-128, -128, -128, -128),
              v(-128, -128, -128, -128), 4'b0101, 1);
        drain();

        // Backpressure: A held, B streams until its last beat stalls.
        thr = '0;
        out_ready = 1'b0;
        frame(v(1, 2, 3, 4), v(1, 2, 3, 4), v(1, 2, 3, 4), v(1, 2, 3, 4),
              v(4, 8, 12, 16), 4'b1111, 1);
        q.push_back('{s: v(-4, -8, -12, -16), b: 4'b0000});
        repeat (3) beat(v(-1, -2, -3, -4));
        in_valid = 1'b1;
        in_data  = v(-1, -2, -3, -4);
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready_low", 64'(in_ready), 64'd0);
            check("bp_hold_sum", 64'(out_sum), 64'(v(4, 8, 12, 16)));
            check("bp_hold_valid", 64'(out_valid), 64'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_b_valid", 64'(out_valid), 64'd1);
        drain();

        // Flush mid-frame with a pending result held.
        out_ready = 1'b0;
        frame(v(2, 2, 2, 2), v(2, 2, 2, 2), v(2, 2, 2, 2), v(2, 2, 2, 2),
              v(8, 8, 8, 8), 4'b1111, 1);
        beat(v(50, 50, 50, 50));
        beat(v(50, 50, 50, 50));
        flush = 1'b1;
        in_valid = 1'b1;
        in_data = v(50, 50, 50, 50);
        @(negedge clk);
        check("flush_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_hold_valid", 64'(out_valid), 64'd1);
        check("flush_hold_sum", 64'(out_sum), 64'(v(8, 8, 8, 8)));
        out_ready = 1'b1;
        frame(v(1, 1, 1, 1), v(1, 1, 1, 1), v(1, 1, 1, 1), v(1, 1, 1, 1),
              v(4, 4, 4, 4), 4'b1111, 1);
        drain();

        // Async reset between edges discards a pending result and a partial frame.
        out_ready = 1'b0;
        frame(v(9, 9, 9, 9), v(9, 9, 9, 9), v(9, 9, 9, 9), v(9, 9, 9, 9),
              v(36, 36, 36, 36), 4'b1111, 0);
        beat(v(9, 9, 9, 9));
        beat(v(9, 9, 9, 9));
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_out_sum", 64'(out_sum), 64'd0);
        check("arst_out_bin", 64'(out_bin), 64'd0);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        frame(v(1, 1, 1, 1), v(1, 1, 1, 1), v(1, 1, 1, 1), v(1, 1, 1, 1),
              v(4, 4, 4, 4), 4'b1111, 1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
